// File: rtl/renkon_ctrl_pkg.sv
// rtl/renkon_ctrl_pkg.sv - shared constants and state encoding for the renkon controllers
package renkon_ctrl_pkg;

    localparam int WTAPS        = 25;
    localparam int PIPE_LAT_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/renkon_delay_line.sv
// rtl/renkon_delay_line.sv - fixed-depth shift register carrying writeback address and tags
module renkon_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // advance every cycle so bubbles keep their place relative to real issues
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/renkon_conv_ctrl.sv
// rtl/renkon_conv_ctrl.sv - convolution sequencer; RENKON_CONV_CTRL_PERF_EN adds stall/run counters
module renkon_conv_ctrl
    import renkon_ctrl_pkg::*;
#(
    parameter int FACCUM   = 10,
    parameter int CWIDTH   = 8,
    parameter int WAWIDTH  = 12,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req,
    input  logic [CWIDTH-1:0]  in_chan,
    input  logic [FACCUM-1:0]  out_size,
    input  logic [WAWIDTH-1:0] weight_base,
    output logic               busy,
    output logic               ack,
    output logic [WAWIDTH-1:0] weight_addr,
    output logic               wreg_we,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [FACCUM-1:0]  mem_feat_addr,
    output logic [FACCUM-1:0]  mem_feat_addr_d1,
    output logic               mem_feat_we,
    output logic               mem_feat_rst,
    output logic               out_en
`ifdef RENKON_CONV_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        run_cnt
`endif
);

    localparam int TAGW = FACCUM + 3;

    state_t             state, state_next;
    logic [CWIDTH-1:0]  chan_q, chan;
    logic [FACCUM-1:0]  size_q, pos;
    logic [4:0]         tap;
    logic               accept, wissue, issue;
    logic               last_pos, last_chan;
    logic [TAGW-1:0]    tag_in, tag_out;

    assign last_pos      = (pos == size_q - FACCUM'(1));
    assign last_chan     = (chan == chan_q - CWIDTH'(1));
    assign mem_feat_addr = pos;

    // state register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state <= S_IDLE;
        else       state <= state_next;
    end

    // next-state and per-cycle strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        wissue     = 1'b0;
        issue      = 1'b0;
        pix_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = (in_chan == '0 || out_size == '0) ? S_DONE : S_WLOAD;
                end
            end
            S_WLOAD: begin
                // tap 0..24 issue weight reads; tap 25 lets the last wreg_we land
                wissue = (tap < 5'(WTAPS));
                if (tap == 5'(WTAPS)) state_next = S_RUN;
            end
            S_RUN: begin
                pix_ready = 1'b1;
                issue     = pix_valid;
                if (pix_valid && last_pos) state_next = last_chan ? S_DRAIN : S_WLOAD;
            end
            S_DRAIN: begin
                if (tap == 5'(PIPE_LAT - 1)) state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // parameter latches, position/channel/tap counters and registered handshake outputs
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            chan_q      <= '0;
            size_q      <= '0;
            chan        <= '0;
            pos         <= '0;
            tap         <= '0;
            weight_addr <= '0;
            wreg_we     <= 1'b0;
            busy        <= 1'b0;
            ack         <= 1'b0;
        end else begin
            wreg_we <= wissue;
            ack     <= (state == S_DONE);
            if (state_next != state)                     tap <= '0;
            else if (state == S_WLOAD || state == S_DRAIN) tap <= tap + 5'd1;
            if (accept) begin
                chan_q      <= in_chan;
                size_q      <= out_size;
                weight_addr <= weight_base;
                chan        <= '0;
                pos         <= '0;
                busy        <= 1'b1;
            end else begin
                if (state == S_DONE) busy <= 1'b0;
                if (wissue) weight_addr <= weight_addr + WAWIDTH'(1);
                if (issue) begin
                    if (last_pos) begin
                        pos <= '0;
                        if (!last_chan) chan <= chan + CWIDTH'(1);
                    end else begin
                        pos <= pos + FACCUM'(1);
                    end
                end
            end
        end
    end

    // bubbles carry zero tags so they never write back
    assign tag_in = {pos, issue, issue && (chan == '0), issue && last_chan};

    renkon_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (TAGW)
    ) u_delay (
        .clk  (clk),
        .xrst (xrst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign {mem_feat_addr_d1, mem_feat_we, mem_feat_rst, out_en} = tag_out;

`ifdef RENKON_CONV_CTRL_PERF_EN
    // stall and busy-cycle counters; cleared on a new job, frozen once idle
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
        end else begin
            if (busy)                      run_cnt   <= run_cnt + 32'd1;
            if (state == S_RUN && !pix_valid) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/renkon_conv_ctrl.md
Name: renkon_conv_ctrl

Overview:
Sequencer for one renkon convolution engine: loads the 25-tap weight register, streams pixel windows, and drives feature-memory addressing and accumulator control.
- Per input channel: weight load, then one pass over all output positions.
- The feature memory accumulates partial sums across channels.
- Sits between the renkon top-level control and the conv datapath; the line buffer supplies pixel windows with a valid/ready handshake.

Parameters:
FACCUM, 10, feature-memory address width (shared ninjin/renkon constant)
CWIDTH, 8, input-channel counter width
WAWIDTH, 12, weight-memory address width
PIPE_LAT, 3, cycles from window issue to accumulator writeback (tree latency + 1 mem read)

Ports:
clk  in  1  clock
xrst  in  1  asynchronous active-low reset
req  in  1  start pulse; sampled in S_IDLE only
in_chan  in  CWIDTH  number of input channels; latched on accepted req
out_size  in  FACCUM  output positions per channel; latched on accepted req
weight_base  in  WAWIDTH  first weight address; latched on accepted req
busy  out  1  high from accepted req until ack
ack  out  1  one-cycle done pulse
weight_addr  out  WAWIDTH  weight-memory read address
wreg_we  out  1  weight-register shift enable; weight_addr delayed 1 cycle
pix_valid  in  1  line buffer has a window on pixel_in0..24
pix_ready  out  1  window consumed this cycle (pix_valid & pix_ready)
mem_feat_addr  out  FACCUM  feature-memory read address (issue stage)
mem_feat_addr_d1  out  FACCUM  write address = mem_feat_addr delayed PIPE_LAT
mem_feat_we  out  1  writeback enable, delayed PIPE_LAT
mem_feat_rst  out  1  accumulator ignores sum_old (channel 0), delayed PIPE_LAT
out_en  out  1  accumulator drives pixel_out (last channel), delayed PIPE_LAT

Behaviour:
- Reset (xrst=0, async): state S_IDLE; all counters and delay-line stages cleared; every output 0.
- FSM states: S_IDLE, S_WLOAD, S_RUN, S_DRAIN, S_DONE.
- S_IDLE:
  - req=1: latch parameters, set busy, clear chan/pos counters.
  - If in_chan==0 or out_size==0, go to S_DONE. Otherwise go to S_WLOAD.
- S_WLOAD:
  - 25 cycles; weight_addr increments by 1 each cycle, continuing across channels (channel c uses weight_base+25c..+25c+24).
  - wreg_we is the 1-cycle-delayed issue strobe, so exactly 25 wreg_we pulses occur per channel.
  - After the last issue, wait 1 cycle for the final wreg_we, then go to S_RUN.
- S_RUN:
  - pix_ready=1. Each handshake cycle issues mem_feat_addr=pos, then pos++.
  - No handshake (pix_valid=0): no issue, pos holds, a bubble enters the delay line.
  - Issue-stage tags: we=1, rst=(chan==0), oen=(chan==in_chan-1).
  - Tags and address pass through a PIPE_LAT-deep shift register that advances every cycle and outputs mem_feat_we/rst/out_en/addr_d1.
  - Last position issued:
    - chan<in_chan-1: chan++, pos=0, go to S_WLOAD.
    - Otherwise go to S_DRAIN.
- Channel change: S_WLOAD lasts ≥26 cycles > PIPE_LAT, so previous writebacks complete before wreg changes (required: PIPE_LAT ≤ 25).
- S_DRAIN: PIPE_LAT cycles until the delay line is empty, then go to S_DONE.
- S_DONE: ack=1 for one cycle; busy drops in the same cycle; go to S_IDLE.
- req while busy is ignored.
- Counters: pos wraps only via FSM reset to 0; weight_addr wraps modulo 2^WAWIDTH without error.
- Single channel: mem_feat_rst and out_en are both high on every writeback.
- Reset mid-operation: immediate abort; no further writebacks; no ack.

Optional Feature:
RENKON_CONV_CTRL_PERF_EN
- Defined: adds outputs stall_cnt[31:0] and run_cnt[31:0].
  - stall_cnt counts S_RUN cycles with pix_valid=0; run_cnt counts busy cycles.
  - Both clear on accepted req, hold after ack, and reset to 0.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package renkon_ctrl_pkg: state encoding constants, WTAPS=25, default PIPE_LAT.
- FACCUM/DWIDTH stay in the existing ninjin/renkon headers.
- One natural sub-module: renkon_delay_line (parameterised depth and width; holds the {addr, we, rst, oen} writeback tags). Reusable by the pool/fully-connected controllers.

Test Plan:
- in_chan=1, out_size=4, pix_valid=1: 25 wreg_we pulses, then mem_feat_we at addr_d1=0,1,2,3 exactly PIPE_LAT cycles after each issue, rst=oen=1; ack once.
- in_chan=3, out_size=2, weight_base=100:
  - weight_addr covers 100..174.
  - rst only on channel 0, out_en only on channel 2.
  - 6 writebacks total.
- in_chan=2, out_size=5, pix_valid toggling 1,0,0,1…: addresses issued in order without skips or repeats; we bubbles match gaps; with PERF_EN, stall_cnt equals the number of pix_valid=0 cycles in S_RUN.
- in_chan=0 or out_size=0: ack 2 cycles after req; no wreg_we, no mem_feat_we.
- req reasserted while busy: ignored; trace identical to a single req.
- xrst low in S_RUN mid-channel: all outputs 0 immediately; no ack; a fresh req afterwards runs a full, correct sequence.
